// File: rtl/mac_pkg.sv
// Shared constants, payload type and elaboration-time helpers for the Dadda MAC pipeline.
package mac_pkg;

  localparam int PIPE_STAGES = 3;

  // Control bits that travel alongside each beat through the pipeline.
  typedef struct packed {
    logic valid;
    logic isSigned;
    logic clear;
    logic last;
  } stageCtrl_t;

  // n-th Dadda target height: 2, 3, 4, 6, 9, 13, ...
  function automatic int dadda_heights(input int n);
    int d;
    d = 2;
    for (int j = 1; j < n; j++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction passes needed for a matrix whose tallest column is maxHeight.
  function automatic int dadda_stages(input int maxHeight);
    int cnt;
    cnt = 0;
    for (int j = 1; j < 32; j++) begin
      if (dadda_heights(j) < maxHeight) cnt++;
    end
    return cnt;
  endfunction

  // Ceiling log2, valid for value >= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int j = 0; j < 31; j++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dadda_reduce.sv
// Combinational Dadda tree: squeezes the partial-product matrix down to two rows.
// Row r of pp_i holds bits that land in columns r..r+WIDTH-1; corr_i is the
// Baugh-Wooley correction bit injected at columns WIDTH and 2*WIDTH-1.
module dadda_reduce
  import mac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp_i,
  input  logic                        corr_i,
  output logic [2*WIDTH-1:0]          sum_o,
  output logic [2*WIDTH-1:0]          carry_o
);

  localparam int COLS    = 2 * WIDTH;
  localparam int ROWS    = WIDTH + 1;
  localparam int NSTAGES = dadda_stages(WIDTH);

  // Each pass walks columns LSB first and applies just enough full/half adders that the column, including carries arriving from its right neighbour, fits the next target height.
  always_comb begin : reduceTree
    logic [ROWS-1:0] curBits [COLS];
    logic [ROWS-1:0] nxtBits [COLS];
    int curCnt [COLS];
    int nxtCnt [COLS];
    int used;
    int remaining;
    int excess;
    int target;
    logic x;
    logic y;
    logic z;

    used      = 0;
    remaining = 0;
    excess    = 0;
    target    = 0;
    x         = 1'b0;
    y         = 1'b0;
    z         = 1'b0;
    sum_o     = '0;
    carry_o   = '0;
    for (int c = 0; c < COLS; c++) begin
      curBits[c] = '0;
      nxtBits[c] = '0;
      curCnt[c]  = 0;
      nxtCnt[c]  = 0;
    end

    for (int r = 0; r < WIDTH; r++) begin
      for (int k = 0; k < WIDTH; k++) begin
        curBits[r+k][curCnt[r+k]] = pp_i[r][k];
        curCnt[r+k] = curCnt[r+k] + 1;
      end
    end
    curBits[WIDTH][curCnt[WIDTH]] = corr_i;
    curCnt[WIDTH] = curCnt[WIDTH] + 1;
    curBits[COLS-1][curCnt[COLS-1]] = corr_i;
    curCnt[COLS-1] = curCnt[COLS-1] + 1;

    for (int s = NSTAGES; s >= 1; s--) begin
      target = dadda_heights(s);
      for (int c = 0; c < COLS; c++) begin
        nxtBits[c] = '0;
        nxtCnt[c]  = 0;
      end
      for (int c = 0; c < COLS; c++) begin
        used = 0;
        for (int k = 0; k < ROWS; k++) begin
          remaining = curCnt[c] - used;
          excess    = remaining + nxtCnt[c] - target;
          if (excess >= 2 && remaining >= 3) begin
            x = curBits[c][used];
            y = curBits[c][used+1];
            z = curBits[c][used+2];
            nxtBits[c][nxtCnt[c]] = x ^ y ^ z;
            nxtCnt[c] = nxtCnt[c] + 1;
            if (c + 1 < COLS) begin
              nxtBits[c+1][nxtCnt[c+1]] = (x & y) | (x & z) | (y & z);
              nxtCnt[c+1] = nxtCnt[c+1] + 1;
            end
            used = used + 3;
          end else if (excess >= 1 && remaining >= 2) begin
            x = curBits[c][used];
            y = curBits[c][used+1];
            nxtBits[c][nxtCnt[c]] = x ^ y;
            nxtCnt[c] = nxtCnt[c] + 1;
            if (c + 1 < COLS) begin
              nxtBits[c+1][nxtCnt[c+1]] = x & y;
              nxtCnt[c+1] = nxtCnt[c+1] + 1;
            end
            used = used + 2;
          end
        end
        for (int k = 0; k < ROWS; k++) begin
          if (k >= used && k < curCnt[c]) begin
            nxtBits[c][nxtCnt[c]] = curBits[c][k];
            nxtCnt[c] = nxtCnt[c] + 1;
          end
        end
      end
      curBits = nxtBits;
      curCnt  = nxtCnt;
    end

    for (int c = 0; c < COLS; c++) begin
      sum_o[c]   = curBits[c][0];
      carry_o[c] = curBits[c][1];
    end
  end

endmodule

// File: rtl/dadda_mac_pipe.sv
// Three-stage pipelined multiply-accumulate with Dadda tree, per-beat signed/unsigned
// mode, saturating accumulator and sequence framing. The whole pipe stalls as one
// while a finished result waits for downstream.
module dadda_mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic                 acc_clear,
  input  logic                 acc_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_overflow
);

  localparam int PW = 2 * WIDTH;

  logic                        advance;
  stageCtrl_t                  stage1_q;
  stageCtrl_t                  stage2_q;
  stageCtrl_t                  stage3_q;
  logic [WIDTH-1:0]            opA_q;
  logic [WIDTH-1:0]            opB_q;
  logic [WIDTH-1:0][WIDTH-1:0] ppRows;
  logic                        ppCorr;
  logic [PW-1:0]               treeSum;
  logic [PW-1:0]               treeCarry;
  logic [PW-1:0]               sum_q;
  logic [PW-1:0]               carry_q;
  logic [PW-1:0]               product_q;
  logic [ACC_WIDTH-1:0]        extProduct;
  logic [ACC_WIDTH-1:0]        accBase;
  logic [ACC_WIDTH-1:0]        clampValue;
  logic [ACC_WIDTH-1:0]        accNext;
  logic [ACC_WIDTH:0]          rawSum;
  logic                        beatOverflow;
  logic                        stickyNext;
  logic [ACC_WIDTH-1:0]        acc_q;
  logic [ACC_WIDTH-1:0]        acc_d;
  logic                        sticky_q;
  logic                        sticky_d;
  logic                        outValid_q;
  logic                        outValid_d;
  logic [ACC_WIDTH-1:0]        outAcc_q;
  logic [ACC_WIDTH-1:0]        outAcc_d;
  logic                        outOverflow_q;
  logic                        outOverflow_d;

  // The only backpressure source is an unconsumed result, so every stage shares one enable.
  always_comb begin
    advance  = !(outValid_q && !out_ready);
    in_ready = advance;
  end

  // Stage 1: capture operands and beat framing; bubbles travel as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
    end else if (advance) begin
      stage1_q.valid    <= in_valid;
      stage1_q.isSigned <= is_signed;
      stage1_q.clear    <= acc_clear;
      stage1_q.last     <= acc_last;
      opA_q             <= a;
      opB_q             <= b;
    end
  end

  // Partial products: row j is a & b[j]; in signed mode the terms pairing exactly one sign bit are inverted (Baugh-Wooley) and the correction bit is enabled.
  always_comb begin
    ppRows = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        ppRows[j][i] = (opA_q[i] & opB_q[j]) ^
                       (stage1_q.isSigned & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
      end
    end
    ppCorr = stage1_q.isSigned;
  end

  dadda_reduce #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .pp_i    (ppRows),
    .corr_i  (ppCorr),
    .sum_o   (treeSum),
    .carry_o (treeCarry)
  );

  // Stage 2 holds the two reduced rows; stage 3 holds the carry-propagated product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage2_q  <= '0;
      stage3_q  <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else if (advance) begin
      stage2_q  <= stage1_q;
      sum_q     <= treeSum;
      carry_q   <= treeCarry;
      stage3_q  <= stage2_q;
      product_q <= sum_q + carry_q;
    end
  end

  // Extend the product by its own beat mode, add to the (optionally cleared) accumulator and clamp on overflow; a last beat also publishes the result.
  always_comb begin
    extProduct = stage3_q.isSigned ? {{(ACC_WIDTH-PW){product_q[PW-1]}}, product_q}
                                   : {{(ACC_WIDTH-PW){1'b0}}, product_q};
    accBase    = stage3_q.clear ? '0 : acc_q;
    rawSum     = {1'b0, accBase} + {1'b0, extProduct};
    if (stage3_q.isSigned) begin
      beatOverflow = (accBase[ACC_WIDTH-1] == extProduct[ACC_WIDTH-1]) &&
                     (rawSum[ACC_WIDTH-1] != accBase[ACC_WIDTH-1]);
      clampValue   = accBase[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      beatOverflow = rawSum[ACC_WIDTH];
      clampValue   = '1;
    end
    accNext    = beatOverflow ? clampValue : rawSum[ACC_WIDTH-1:0];
    stickyNext = (stage3_q.clear ? 1'b0 : sticky_q) | beatOverflow;

    acc_d         = acc_q;
    sticky_d      = sticky_q;
    outValid_d    = outValid_q;
    outAcc_d      = outAcc_q;
    outOverflow_d = outOverflow_q;

    if (advance && stage3_q.valid) begin
      acc_d    = accNext;
      sticky_d = stickyNext;
    end
    if (advance && stage3_q.valid && stage3_q.last) begin
      outValid_d    = 1'b1;
      outAcc_d      = accNext;
      outOverflow_d = stickyNext;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Accumulator, sticky overflow and output holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      sticky_q      <= 1'b0;
      outValid_q    <= 1'b0;
      outAcc_q      <= '0;
      outOverflow_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      sticky_q      <= sticky_d;
      outValid_q    <= outValid_d;
      outAcc_q      <= outAcc_d;
      outOverflow_q <= outOverflow_d;
    end
  end

  assign out_valid    = outValid_q;
  assign out_acc      = outAcc_q;
  assign out_overflow = outOverflow_q;

endmodule

// File: tb/tb_dadda_mac_pipe.sv
// Directed bench for dadda_mac_pipe at WIDTH=8, ACC_WIDTH=24: single-beat vector
// table plus hand-built sequences for saturation, stalls, bubbles and reset.
module tb_dadda_mac_pipe;

  localparam int W  = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          acc_clear;
  logic          acc_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          out_overflow;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] resAccQ[$];
  logic          resOvfQ[$];

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sgn;
    logic [AW-1:0] expAcc;
    logic          expOvf;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  dadda_mac_pipe #(
    .WIDTH     (W),
    .ACC_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .is_signed    (is_signed),
    .acc_clear    (acc_clear),
    .acc_last     (acc_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_overflow (out_overflow)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Record every result that will be handed over at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      resAccQ.push_back(out_acc);
      resOvfQ.push_back(out_overflow);
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at 1 ms, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one beat and hold it until it is accepted at a rising edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic sg, input logic cl, input logic ls);
    int waitCnt;
    waitCnt   = 0;
    a         = av;
    b         = bv;
    is_signed = sg;
    acc_clear = cl;
    acc_last  = ls;
    in_valid  = 1'b1;
    while (!in_ready && waitCnt < 50) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready=%0d after 50 cycles, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send n identical beats as one framed sequence, back to back.
  task automatic runSequence(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic sg, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(av, bv, sg, (i == 0), (i == n - 1));
    end
    in_valid = 1'b0;
  endtask

  // Pop the next captured result, treating a missing one as a failure.
  task automatic waitResult(input string name, input longint expAcc, input longint expOvf);
    int cnt;
    logic [AW-1:0] gotAcc;
    logic          gotOvf;
    cnt = 0;
    while (resAccQ.size() == 0 && cnt < 100) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    if (resAccQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: no result within 100 cycles, expected acc %0d", name, expAcc);
    end else begin
      gotAcc = resAccQ.pop_front();
      gotOvf = resOvfQ.pop_front();
      checkOutput({name, "_acc"}, gotAcc, expAcc);
      checkOutput({name, "_ovf"}, gotOvf, expOvf);
    end
  endtask

  initial begin
    int lat;

    vecs[0]  = '{8'd255,  8'd255,  1'b0, 24'd65025,    1'b0};
    vecs[1]  = '{8'h80,   8'h80,   1'b1, 24'd16384,    1'b0};
    vecs[2]  = '{8'hFF,   8'h7F,   1'b1, 24'd16777089, 1'b0};
    vecs[3]  = '{8'h05,   8'hFD,   1'b1, 24'd16777201, 1'b0};
    vecs[4]  = '{8'h7F,   8'h7F,   1'b1, 24'd16129,    1'b0};
    vecs[5]  = '{8'h80,   8'h7F,   1'b1, 24'd16760960, 1'b0};
    vecs[6]  = '{8'd0,    8'd200,  1'b0, 24'd0,        1'b0};
    vecs[7]  = '{8'd200,  8'd3,    1'b0, 24'd600,      1'b0};
    vecs[8]  = '{8'h80,   8'h80,   1'b0, 24'd16384,    1'b0};
    vecs[9]  = '{8'hFF,   8'h01,   1'b1, 24'd16777215, 1'b0};
    vecs[10] = '{8'hAB,   8'hCD,   1'b0, 24'd35055,    1'b0};
    vecs[11] = '{8'hAB,   8'hCD,   1'b1, 24'd4335,     1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    acc_clear = 1'b0;
    acc_last  = 1'b0;
    out_ready = 1'b1;

    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_acc", out_acc, 0);
    checkOutput("reset_out_overflow", out_overflow, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2);

    // Single-beat products with latency measured from the accepting edge.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b1, 1'b1);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput($sformatf("vec%0d_latency", i), lat, 3);
      waitResult($sformatf("vec%0d", i), vecs[i].expAcc, vecs[i].expOvf);
    end
    idleCycles(2);

    // Signed three-beat sequence: 16384 - 127 - 15.
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h05, 8'hFD, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("signed3", 16242, 0);

    // Signed saturation boundary.
    runSequence(8'h80, 8'h80, 1'b1, 511);
    waitResult("signed511", 8372224, 0);
    runSequence(8'h80, 8'h80, 1'b1, 512);
    waitResult("signed512", 8388607, 1);

    // Unsigned saturation boundary.
    runSequence(8'd255, 8'd255, 1'b0, 258);
    waitResult("unsigned258", 16776450, 0);
    runSequence(8'd255, 8'd255, 1'b0, 259);
    waitResult("unsigned259", 16777215, 1);

    // Continuing without clear keeps the saturated value and the sticky flag.
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("continue_sticky", 16777215, 1);

    // Clear drops the sticky flag; a following no-clear beat accumulates on top.
    applyStimulus(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd1, 8'd4, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("cont_first", 6, 0);
    waitResult("cont_second", 10, 0);

    // Bubbles inside a sequence leave the accumulator alone.
    applyStimulus(8'd2, 8'd2, 1'b0, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(8'd3, 8'd3, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("bubble", 13, 0);

    // Mixed modes: unsigned 255*255 then signed -1*1.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("mixed", 65024, 0);
    idleCycles(2);

    // Back-to-back results with downstream stalled.
    out_ready = 1'b0;
    applyStimulus(8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd6, 8'd7, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_out_acc", out_acc, 12);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("handover_out_valid", out_valid, 1);
    checkOutput("handover_out_acc", out_acc, 42);
    waitResult("stall_first", 12, 0);
    waitResult("stall_second", 42, 0);
    idleCycles(10);
    checkOutput("stall_extra_results", resAccQ.size(), 0);

    // Reset mid-sequence with a held result and beats in flight.
    out_ready = 1'b0;
    applyStimulus(8'd9, 8'd9, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'd10, 8'd10, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd20, 8'd20, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("prereset_out_valid", out_valid, 1);
    checkOutput("prereset_out_acc", out_acc, 81);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_out_acc", out_acc, 0);
    checkOutput("midreset_out_overflow", out_overflow, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    idleCycles(6);
    checkOutput("postreset_no_result", resAccQ.size(), 0);
    applyStimulus(8'd2, 8'd3, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    waitResult("postreset_noclear", 6, 0);
    applyStimulus(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    waitResult("postreset_fresh", 6, 0);
    idleCycles(8);
    checkOutput("postreset_extra_results", resAccQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
